// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage access unit.
package mem_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam int TIMEOUT_DEFAULT = 64;

  function automatic logic is_load(input mem_op_e op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Words need a 4-byte boundary, halves a 2-byte boundary, bytes anything.
  function automatic logic is_aligned(input mem_op_e op, input logic [1:0] off);
    logic ok;
    case (op)
      OP_LW, OP_SW:         ok = (off == 2'b00);
      OP_LH, OP_LHU, OP_SH: ok = (off[0] == 1'b0);
      default:              ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// load_ext: picks the addressed byte/half lane out of a bus word and
// sign- or zero-extends it. Purely combinational so MEM/WB forwarding can reuse it.
module load_ext
  import mem_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension according to the load flavour.
  always_comb begin
    byte_sel = 8'h00;
    half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
    case (byte_off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    case (op)
      OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data = {24'h000000, byte_sel};
      OP_LH:   data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data = {16'h0000, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: runs one req/ack data-memory transaction for the
// instruction held in EX/MEM, stalling the front of the pipe until it completes.
// Optional build macro MEM_TIMEOUT_EN adds a BUSY watchdog that raises busErr.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_Mem,
  input  logic [3:0]        memOp_Mem,
  input  logic [ADDR_W-1:0] aluAns_Mem,
  input  logic [DATA_W-1:0] grfRd2_Mem,
  input  logic              kill_Mem,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] ldData,
  output logic              ldValid,
  output logic              addrErr,
  output logic              busErr
);

  mem_state_e  state;
  mem_op_e     op_in;
  mem_op_e     op_q;
  logic [1:0]  off_q;
  logic        req_present;
  logic        aligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] ext_data;

  assign op_in       = mem_op_e'(memOp_Mem);
  assign req_present = valid_Mem & (is_load(op_in) | is_store(op_in)) & ~kill_Mem;
  assign aligned     = is_aligned(op_in, aluAns_Mem[1:0]);
  assign stall       = (state == BUSY) | ((state == IDLE) & req_present & aligned);

  // Byte enables and lane-replicated write data for the request being accepted.
  always_comb begin
    be_next    = BE_WORD;
    wdata_next = 32'h0;
    case (op_in)
      OP_SB: begin
        be_next    = 4'b0001 << aluAns_Mem[1:0];
        wdata_next = {4{grfRd2_Mem[7:0]}};
      end
      OP_SH: begin
        be_next    = aluAns_Mem[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{grfRd2_Mem[15:0]}};
      end
      OP_SW:   wdata_next = grfRd2_Mem;
      default: be_next    = BE_WORD;
    endcase
  end

  load_ext u_load_ext (
    .op       (op_q),
    .byte_off (off_q),
    .rdata    (bus_rdata),
    .data     (ext_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int TimerW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TimerW-1:0] timer;
  logic              timeout_hit;
  assign timeout_hit = (timer == TimerW'(TIMEOUT_CYCLES - 1));
`endif

  // Access FSM: IDLE accepts, BUSY holds the bus until ack, DONE releases the pipe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_q      <= OP_NONE;
      off_q     <= 2'b00;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= BE_NONE;
      bus_wdata <= '0;
      ldData    <= '0;
      ldValid   <= 1'b0;
      addrErr   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      busErr    <= 1'b0;
      timer     <= '0;
`endif
    end else begin
      ldValid <= 1'b0;
      addrErr <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      busErr  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_present) begin
            if (aligned) begin
              op_q      <= op_in;
              off_q     <= aluAns_Mem[1:0];
              bus_req   <= 1'b1;
              bus_we    <= is_store(op_in);
              bus_addr  <= {aluAns_Mem[ADDR_W-1:2], 2'b00};
              bus_be    <= be_next;
              bus_wdata <= wdata_next;
              state     <= BUSY;
`ifdef MEM_TIMEOUT_EN
              timer     <= '0;
`endif
            end else begin
              addrErr <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= DONE;
            if (is_load(op_q)) begin
              ldData  <= ext_data;
              ldValid <= 1'b1;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (timeout_hit) begin
            bus_req <= 1'b0;
            busErr  <= 1'b1;
            state   <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MEM_TIMEOUT_EN
  assign busErr = 1'b0;
`endif

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage consumer of the EX/MEM pipeline register outputs. Takes the decoded load/store request, ALU address and store data held in EX/MEM.
- Runs one transaction on a variable-latency data-memory bus (req/ack handshake).
- Drives stall upstream until the access completes, then presents the aligned and extended load result for the MEM/WB register.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, bus data width (fixed 32; the byte-lane logic assumes 4 lanes)
- TIMEOUT_CYCLES, 64, watchdog limit; used only with MEM_TIMEOUT_EN

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- valid_Mem  in  1  EX/MEM holds a live instruction
- memOp_Mem  in  4  op code: NONE, LW, LH, LHU, LB, LBU, SW, SH, SB (package enum)
- aluAns_Mem  in  32  effective byte address
- grfRd2_Mem  in  32  store data (rt)
- kill_Mem  in  1  flush; request squashed only if not yet issued
- stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM
- bus_req  out  1  memory request
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  bus completes the request in this cycle
- bus_rdata  in  32  read data, valid when bus_ack=1
- ldData  out  32  extended load result
- ldValid  out  1  ldData valid; one-cycle pulse
- addrErr  out  1  misaligned access; one-cycle pulse
- busErr  out  1  watchdog timeout; one-cycle pulse (tied 0 without MEM_TIMEOUT_EN)

Behaviour:
- Reset (reset=0, async): state=IDLE. bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, ldData=0, ldValid=0, addrErr=0, busErr=0, timer=0.
- FSM states: IDLE, BUSY, DONE.
- Request present = valid_Mem & memOp_Mem!=NONE & ~kill_Mem.
- Aligned = LW/SW need addr[1:0]==0; LH/LHU/SH need addr[0]==0; byte ops are always aligned.
- IDLE, request present and aligned:
  - At the next edge: latch bus_addr, bus_be, bus_we and bus_wdata; set bus_req=1; go to BUSY.
  - stall=1 combinationally in this cycle.
- IDLE, request present and misaligned:
  - No bus access; stay in IDLE.
  - addrErr=1 for one cycle, registered at the next edge.
  - stall=0.
- BUSY:
  - stall=1.
  - bus_req and all bus_* outputs are held stable until bus_ack=1 is sampled.
  - On ack: bus_req=0, go to DONE. For loads, ldData is registered from bus_rdata at that edge.
  - kill_Mem is ignored; an issued transaction always completes.
- DONE:
  - stall=0, ldValid=1 for loads (0 for stores). The pipeline advances at the end of this cycle.
  - The next state is always IDLE. The still-visible EX/MEM contents are not re-accepted.
- Minimum latency: acceptance cycle N, bus_req in N+1; if ack in N+1, DONE in N+2. That is 2 stall cycles.
- Store byte enables by addr[1:0]:
  - SB: be = 0001 << addr[1:0]; wdata = {4{rt[7:0]}}.
  - SH: be = 0011 (addr[1]=0) or 1100 (addr[1]=1); wdata = {2{rt[15:0]}}.
  - SW: be = 1111.
- Loads: bus_be=1111. In the ack cycle, select the byte lane (LB/LBU) or half lane (LH/LHU) using the latched addr[1:0], then sign- or zero-extend to 32 bits.
- bus_ack while not BUSY: ignored.
- Async reset asserted mid-BUSY: bus_req drops immediately and no result is produced.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - On reaching TIMEOUT_CYCLES: drop bus_req, pulse busErr, go to DONE with ldValid=0 and ldData unchanged.
- Undefined: no counter exists, busErr is tied to 0, and BUSY waits indefinitely.

Decomposition:
- Shared package mem_pkg holds:
  - memOp enum (4-bit codes)
  - FSM state enum
  - constants BE_WORD=4'b1111 and BE_NONE=4'b0000
  - TIMEOUT default
- One natural sub-module: load_ext (combinational lane select plus sign/zero extend). It is reused by MEM/WB forwarding.

Test Plan:
- LW addr 0x0000_1004, ack one cycle after req, rdata 0xDEADBEEF -> bus_addr 0x1004, be 1111, stall high 2 cycles, ldValid pulse with ldData 0xDEADBEEF.
- LB addr 0x1003, rdata 0x80FF_0000 -> ldData 0xFFFFFF80; LBU at the same address -> 0x00000080; LH at 0x1002 -> 0xFFFF80FF.
- SB addr 0x2001, rt 0x1234_56AB -> be 0010, wdata 0xABABABAB, we=1, ldValid stays 0; SH at 0x2002 -> be 1100, wdata 0x56AB56AB.
- LW at 0x1002 -> addrErr pulse, bus_req never asserted, stall 0.
- kill_Mem in the acceptance cycle -> no req. kill_Mem in BUSY with ack delayed 5 cycles -> transaction still completes; stall high 6 cycles.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, ack never asserted -> busErr pulse after 8 BUSY cycles, bus_req drops, FSM returns to IDLE. Reset asserted mid-BUSY -> all outputs zero immediately.
